// File: rtl/riscv_pkg.sv
// Shared RV32 constants, fetch FSM encoding and the IF/ID payload type.
package riscv_pkg;

  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_L  = 7'b0000011;
  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_S  = 7'b0100011;
  localparam logic [6:0] OPC_U  = 7'b0110111;
  localparam logic [6:0] OPC_SB = 7'b1100011;
  localparam logic [6:0] OPC_UJ = 7'b1101111;

  // addi x0,x0,0: decodes as no register write and no memory access
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake plus the IF/ID, stall and redirect signals of the fetch stage.
interface fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] ifIdInstr;
  logic [31:0] ifIdPc;
  logic        ifIdValid;

  modport master (
    output imemReq, imemAddr, ifIdInstr, ifIdPc, ifIdValid,
    input  imemGnt, imemRvalid, imemRdata, stall, redirect, redirectPc
  );

  modport slave (
    input  imemReq, imemAddr, ifIdInstr, ifIdPc, ifIdValid,
    output imemGnt, imemRvalid, imemRdata, stall, redirect, redirectPc
  );
endinterface

// File: rtl/ifid_reg.sv
// Pipeline stage register: flush beats load, hold suppresses load.
module ifid_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  flush_i,
  input  logic  hold_i,
  input  ifid_t data_i,
  output ifid_t data_o,
  output logic  valid_o
);

  ifid_t data_q;
  logic  valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      data_q  <= '{instr: NOP_INSTR, pc: 32'h0};
      valid_q <= 1'b0;
    end else if (load_i && !hold_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, one outstanding imem request at a time, feeds IF/ID.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         req_q;
  ifid_t        buf_q;

  logic  gnt_acc;
  logic  owe_rsp;
  logic  ifid_load;
  ifid_t ifid_d;
  ifid_t ifid_q;

  assign gnt_acc = (state_q == FETCH_REQ) && req_q && bus.imemGnt;

  // On redirect a response is still owed unless it arrives this very cycle.
  assign owe_rsp = gnt_acc ||
                   (((state_q == FETCH_WAIT) || (state_q == FETCH_DRAIN)) && !bus.imemRvalid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      buf_q   <= '0;
    end else if (bus.redirect) begin
      pc_q    <= {bus.redirectPc[31:2], 2'b00};
      buf_q   <= '0;
      state_q <= owe_rsp ? FETCH_DRAIN : FETCH_REQ;
      req_q   <= !owe_rsp;
    end else begin
      case (state_q)
        FETCH_REQ: begin
          req_q <= 1'b1;
          if (gnt_acc) begin
            state_q <= FETCH_WAIT;
            req_q   <= 1'b0;
          end
        end
        FETCH_WAIT: begin
          if (bus.imemRvalid) begin
            pc_q <= pc_q + 32'd4;
            if (bus.stall) begin
              buf_q   <= '{instr: bus.imemRdata, pc: pc_q};
              state_q <= FETCH_HOLD;
            end else begin
              state_q <= FETCH_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        FETCH_HOLD: begin
          if (!bus.stall) begin
            state_q <= FETCH_REQ;
            req_q   <= 1'b1;
          end
        end
        FETCH_DRAIN: begin
          if (bus.imemRvalid) begin
            state_q <= FETCH_REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= FETCH_REQ;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ifid_load = ((state_q == FETCH_WAIT) && bus.imemRvalid) || (state_q == FETCH_HOLD);
  assign ifid_d    = (state_q == FETCH_HOLD) ? buf_q
                                             : '{instr: bus.imemRdata, pc: pc_q};

  ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .flush_i (bus.redirect),
    .hold_i  (bus.stall),
    .data_i  (ifid_d),
    .data_o  (ifid_q),
    .valid_o (bus.ifIdValid)
  );

  assign bus.imemReq   = req_q;
  assign bus.imemAddr  = pc_q;
  assign bus.ifIdInstr = ifid_q.instr;
  assign bus.ifIdPc    = ifid_q.pc;

endmodule
